gf_power_seq: RTL and testbench
===============================

Name: gf_power_seq

Overview:
- Sequential exponentiation engine over GF(2^N) in polynomial basis: y = x^e, with the exponent e supplied per transaction.
- Generalises the fixed-exponent, fixed-width combinational power maps in the S-box library to a runtime exponent, parametrised field width and reduction polynomial.
- Uses left-to-right square-and-multiply, one exponent bit per cycle, with valid/ready handshakes on input and output.
- Sits beside the S-box generators as a shared, area-cheap power-map core for design-space sweeps.

Parameters:
- N, 6, field width in bits.
- POLY, 7'b1000011, irreducible reduction polynomial, N+1 bits, MSB must be 1 (default x^6+x+1).
- EXP_W, 6, exponent width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  engine can accept an operand pair.
- x_in  input  N  base element, polynomial basis.
- e_in  input  EXP_W  exponent, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- y_out  output  N  result x^e.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: the one clock is clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, y_out=0, busy=0, internal acc/base/exp/count=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch base=x_in, exp=e_in, set acc=1, set count=EXP_W, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: acc <= sq(acc) * (exp[MSB] ? base : 1) mod POLY; shift exp left by 1; decrement count.
  - When count reaches 1 (last bit consumed this cycle), go to DONE.
- DONE:
  - out_valid=1; y_out=acc, held stable until accepted.
  - On out_ready: go to IDLE and drop out_valid on the same edge.
  - in_ready rises the cycle after the handoff; there is no overlap between transactions.
- Latency (macro off): out_valid asserts exactly EXP_W cycles after the accepting edge. Throughput is one result per EXP_W+2 cycles with out_ready held high.
- Arithmetic:
  - Square and multiply are full GF(2^N) operations reduced by POLY, combinational within one cycle.
  - Squaring is a linear map generated from POLY.
  - Multiply is schoolbook carry-less, then reduction.
- Boundary cases:
  - e=0 gives y=1 for any x, including x=0.
  - x=0 with e>0 gives 0.
  - e=2^N-1 with x≠0 gives 1.
  - Exponents at or above 2^N-1 are not reduced; the result follows normal exponent arithmetic.
- Reset mid-operation: any in-flight result is discarded and the FSM returns to IDLE with reset values; out_valid never glitches high.
- in_valid outside IDLE is ignored, with no latching.
- out_ready outside DONE is ignored.

Optional Feature:
- Macro: GF_POWER_SEQ_EARLY_TERM_EN.
- Defined:
  - On accept, leading zero bits of e_in are skipped: count is set to floor(log2 e)+1 and exp is pre-shifted so its MSB is the leading one.
  - e_in=0 goes IDLE→DONE with acc=1 after 1 cycle.
  - Latency = max(1, floor(log2 e)+1) cycles.
- Undefined: fixed EXP_W-cycle latency for all e. Results are identical either way.

Test Plan:
- Default parameters, x=0x02, e=1 → y_out=0x02; out_valid 6 cycles after accept (macro off).
- x=0x02, e=6 → 0x03; e=7 → 0x06; e=12 → 0x05; e=63 → 0x01.
- x=0x00, e=0 → 0x01; x=0x00, e=5 → 0x00; x=0x2B, e=0 → 0x01.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → y_out stable, in_ready=0, a pulsed in_valid is ignored. On release, in_ready=1 the next cycle.
- Assert rst at cycle 3 of RUN → next cycle state IDLE, out_valid=0, y_out=0, in_ready=1. A new x=0x02, e=6 then returns 0x03.
- Macro on: e=1 → latency 1; e=12 → latency 4; e=0 → latency 1 with y=0x01. A sweep of all 64×64 (x, e) pairs matches the macro-off results and a software GF(2^6) model.

Source files
------------

// File: rtl/gf_power_seq.sv
// gf_power_seq -- sequential GF(2^N) power map, y = x^e, polynomial basis.
//
// Left-to-right square-and-multiply, one exponent bit per cycle. Operands
// enter on a valid/ready handshake and the result leaves on another; only
// one transaction is in flight at a time.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   engine idle, can accept an operand pair
//   x_in       base element (N bits)
//   e_in       exponent, unsigned (EXP_W bits)
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   y_out      result x^e (zero while no result is presented)
//   busy       high while computing or holding a result
//
// Build option: GF_POWER_SEQ_EARLY_TERM_EN skips the leading zero bits of
// the exponent, giving max(1, bitlen(e)) cycles of latency instead of
// EXP_W. Results are identical either way.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | consuming one exponent bit per cycle
// DONE  | result presented on y_out until out_ready

module gf_power_seq #(
   parameter int          N     = 6,
   parameter logic [N:0]  POLY  = 7'b1000011,
   parameter int          EXP_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     x_in,
   input  logic [EXP_W-1:0] e_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     y_out,
   output logic             busy
);

   localparam int CNT_W = $clog2(EXP_W + 1);
   localparam logic [N-1:0] ONE = N'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       acc_q, acc_d;
   logic [N-1:0]       base_q, base_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Fold the high-order terms of a 2N-1 bit product back into N bits.
   function automatic logic [N-1:0] gf_reduce(input logic [2*N-2:0] p);
      logic [2*N-2:0] r;
      r = p;
      for (int i = 2*N-2; i >= N; i--) begin
         if (r[i]) r[i -: N+1] = r[i -: N+1] ^ POLY;
      end
      return r[N-1:0];
   endfunction

   // Squaring is linear over GF(2): spread bit i to bit 2i, then reduce.
   function automatic logic [N-1:0] gf_sq(input logic [N-1:0] a);
      logic [2*N-2:0] p;
      p = '0;
      for (int i = 0; i < N; i++) p[2*i] = a[i];
      return gf_reduce(p);
   endfunction

   function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a,
                                           input logic [N-1:0] b);
      logic [2*N-2:0] p;
      p = '0;
      for (int i = 0; i < N; i++) begin
         if (b[i]) p = p ^ ({{(N-1){1'b0}}, a} << i);
      end
      return gf_reduce(p);
   endfunction

   logic [N-1:0] acc_step;
   assign acc_step = gf_mul(gf_sq(acc_q), exp_q[EXP_W-1] ? base_q : ONE);

`ifdef GF_POWER_SEQ_EARLY_TERM_EN
   logic [CNT_W-1:0] e_len;
   always_comb begin
      e_len = '0;
      for (int i = 0; i < EXP_W; i++) begin
         if (e_in[i]) e_len = CNT_W'(i + 1);
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      base_d    = base_q;
      exp_d     = exp_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      y_out     = '0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               base_d  = x_in;
               acc_d   = ONE;
               state_d = RUN;
`ifdef GF_POWER_SEQ_EARLY_TERM_EN
               // e=0 still takes one pass: exp is all zero so acc stays 1.
               exp_d = e_in << (EXP_W - int'(e_len));
               cnt_d = (e_len == '0) ? CNT_W'(1) : e_len;
`else
               exp_d = e_in;
               cnt_d = CNT_W'(EXP_W);
`endif
            end
         end
         RUN: begin
            busy  = 1'b1;
            acc_d = acc_step;
            exp_d = exp_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            y_out     = acc_q;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         base_q  <= '0;
         exp_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         base_q  <= base_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_gf_power_seq.sv
// Directed bench for gf_power_seq with default parameters (GF(2^6),
// x^6+x+1). Expected results come from hand-computed constants and a
// repeated-multiplication reference model.
module tb_gf_power_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] x_in;
   logic [5:0] e_in;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] y_out;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gf_power_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .e_in      (e_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_out     (y_out),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: shift-and-xor multiply with x^6 = x + 1 folded in per step.
   function automatic logic [5:0] m_mul(input logic [5:0] a, input logic [5:0] b);
      logic [5:0] r, aa;
      r  = '0;
      aa = a;
      for (int i = 0; i < 6; i++) begin
         if (b[i]) r = r ^ aa;
         aa = {aa[4:0], 1'b0} ^ (aa[5] ? 6'h03 : 6'h00);
      end
      return r;
   endfunction

   function automatic logic [5:0] m_pow(input logic [5:0] x, input int e);
      logic [5:0] r;
      r = 6'h01;
      for (int i = 0; i < e; i++) r = m_mul(r, x);
      return r;
   endfunction

   function automatic int exp_lat(input int e);
`ifdef GF_POWER_SEQ_EARLY_TERM_EN
      int len;
      len = 0;
      for (int i = 0; i < 6; i++) if (e[i]) len = i + 1;
      return (len == 0) ? 1 : len;
`else
      return 6;
`endif
   endfunction

   // Called #1 after a rising edge with the engine idle.
   task automatic run(input string tag, input logic [5:0] x, input logic [5:0] e,
                      input logic [5:0] y_exp, input bit chk_lat);
      int lat;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      x_in     = x;
      e_in     = e;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'(exp_lat(int'(e))));
      check({tag, "_y"}, 32'(y_out), 32'(y_exp));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (chk_lat) check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x_in      = '0;
      e_in      = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y_out",     32'(y_out),     32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run("x02_e1",  6'h02, 6'd1,  6'h02, 1'b1);
      run("x02_e6",  6'h02, 6'd6,  6'h03, 1'b1);
      run("x02_e7",  6'h02, 6'd7,  6'h06, 1'b1);
      run("x02_e12", 6'h02, 6'd12, 6'h05, 1'b1);
      run("x02_e63", 6'h02, 6'd63, 6'h01, 1'b1);
      run("x00_e0",  6'h00, 6'd0,  6'h01, 1'b1);
      run("x00_e5",  6'h00, 6'd5,  6'h00, 1'b1);
      run("x2B_e0",  6'h2B, 6'd0,  6'h01, 1'b1);

      // Backpressure: result held, new operands refused while in DONE.
      in_valid = 1'b1; x_in = 6'h02; e_in = 6'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_busy_run", 32'(busy), 32'd1);
      for (int i = 0; i < 64 && !out_valid; i++) begin
         @(posedge clk); #1;
      end
      check("bp_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 4);
         x_in     = 6'h05;
         e_in     = 6'd1;
         @(posedge clk); #1;
         check("bp_y_stable",  32'(y_out),     32'h06);
         check("bp_in_ready",  32'(in_ready),  32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_in_ready", 32'(in_ready),  32'd1);
      check("bp_release_valid",    32'(out_valid), 32'd0);
      check("bp_release_busy",     32'(busy),      32'd0);

      // Reset in the third RUN cycle discards the operation.
      in_valid = 1'b1; x_in = 6'h02; e_in = 6'd63;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_y_out",     32'(y_out),     32'd0);
      check("mid_rst_in_ready",  32'(in_ready),  32'd1);
      check("mid_rst_busy",      32'(busy),      32'd0);
      run("post_rst_x02_e6", 6'h02, 6'd6, 6'h03, 1'b1);

      // Full sweep against the reference model.
      for (int x = 0; x < 64; x++) begin
         for (int e = 0; e < 64; e++) begin
            run("sweep", 6'(x), 6'(e), m_pow(6'(x), e), 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
